// File: rtl/kgp_pkg.sv
// kgp_pkg: shared definitions for the KGP-RISC fetch stage.
//   fetch_state_t : fetch controller states
//   INSTR_W       : instruction word width
//   PC_STEP       : byte distance between consecutive instruction words
package kgp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        FULL  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/kgp_fetch_unit.sv
// kgp_fetch_unit: instruction-fetch stage of the KGP-RISC multi-cycle core.
// Owns the PC, issues word reads over a req/ack bus, latches the returned
// word into the IR and offers it downstream over valid/ready. Taken-branch
// redirects retarget the PC; a bus error parks the unit until reset.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   fetch_en                   permits new fetch requests
//   imem_req/imem_addr         registered read request and word address
//   imem_ack/imem_rdata/imem_err  memory response (err qualified by ack)
//   ir/ir_pc/npc/ir_valid      held instruction, its PC, PC+4, valid flag
//   ir_ready                   consumer accepts the held instruction
//   redirect/redirect_pc       taken-branch pulse and target
//   fault                      sticky fetch bus error
module kgp_fetch_unit
    import kgp_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_err,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic [ADDR_W-1:0]  npc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fault
);

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] redirect_tgt_s;

    // Next sequential PC; wraps naturally at ADDR_W bits.
    assign pc_inc_s       = pc_r + ADDR_W'(PC_STEP);
    // Branch targets are forced word-aligned.
    assign redirect_tgt_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};

    // Fetch controller: state, PC, bus request and instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= {ADDR_W{1'b0}};
            ir        <= {INSTR_W{1'b0}};
            ir_pc     <= {ADDR_W{1'b0}};
            npc       <= {ADDR_W{1'b0}};
            ir_valid  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect) begin
                        pc_r     <= redirect_tgt_s;
                        ir_valid <= 1'b0;
                    end else if (fetch_en) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                        state_r   <= FETCH;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        pc_r     <= redirect_tgt_s;
                        ir_valid <= 1'b0;
                        if (imem_ack) begin
                            // Response for the stale address is dropped and
                            // the target is requested right away.
                            imem_req  <= 1'b1;
                            imem_addr <= redirect_tgt_s;
                            state_r   <= FETCH;
                        end else begin
                            // Request stays on the bus until memory answers.
                            state_r <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (imem_err) begin
                            fault   <= 1'b1;
                            state_r <= FAULT;
                        end else begin
                            ir       <= imem_rdata;
                            ir_pc    <= pc_r;
                            npc      <= pc_inc_s;
                            pc_r     <= pc_inc_s;
                            ir_valid <= 1'b1;
                            state_r  <= FULL;
                        end
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_r <= redirect_tgt_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_ack) begin
                        // Stale response retired; restart at the latest PC.
                        if (fetch_en) begin
                            imem_req  <= 1'b1;
                            imem_addr <= redirect ? redirect_tgt_s : pc_r;
                            state_r   <= FETCH;
                        end else begin
                            imem_req <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                FULL: begin
                    if (redirect || ir_ready) begin
                        // Redirect squashes the held word even if ir_ready
                        // is high in the same cycle.
                        ir_valid <= 1'b0;
                        if (redirect) begin
                            pc_r <= redirect_tgt_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                        if (fetch_en) begin
                            imem_req  <= 1'b1;
                            imem_addr <= redirect ? redirect_tgt_s : pc_r;
                            state_r   <= FETCH;
                        end else begin
                            imem_req <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        ir_valid <= 1'b1;
                    end
                end
                FAULT: begin
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                    fault    <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kgp_fetch_unit.md
# kgp_fetch_unit

Instruction-fetch stage of the KGP-RISC multi-cycle core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and latches the returned word into the instruction register. It presents the instruction word, its PC and the next PC to the controller/datapath over a valid/ready handshake. It accepts taken-branch redirects from the branch logic.

## Interface
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset (must be word-aligned)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- fetch_en  in  1  permits new fetch requests
- imem_req  out  1  read request, registered
- imem_addr  out  ADDR_W  read address, registered, stable while imem_req=1
- imem_ack  in  1  memory response strobe, one cycle per request
- imem_rdata  in  32  instruction word, valid with imem_ack
- imem_err  in  1  bus error, qualified by imem_ack
- ir  out  32  instruction register
- ir_pc  out  ADDR_W  address of the word in ir
- npc  out  ADDR_W  ir_pc + 4
- ir_valid  out  1  ir/ir_pc/npc valid
- ir_ready  in  1  consumer accepts the instruction
- redirect  in  1  branch taken, one-cycle pulse
- redirect_pc  in  ADDR_W  branch target; bits [1:0] forced to 0
- fault  out  1  sticky fetch bus error

## Operation
- States: IDLE, FETCH, DRAIN, FULL, FAULT.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, ir=0, ir_pc=0, npc=0, ir_valid=0, fault=0.
- IDLE:
  - fetch_en=1 → FETCH; imem_req=1, imem_addr=pc.
- FETCH:
  - Hold imem_req and imem_addr until imem_ack.
  - On ack with err=0: ir=rdata, ir_pc=pc, npc=pc+4, pc=pc+4, ir_valid=1 → FULL.
  - On ack with err=1: fault=1, imem_req=0 → FAULT.
- FULL:
  - ir_valid held; ir, ir_pc and npc stay stable.
  - ir_ready=1: ir_valid=0 → FETCH if fetch_en=1 (imem_req=1, imem_addr=pc), else IDLE.
- DRAIN:
  - An outstanding request is never abandoned: imem_req and the old imem_addr are held until ack.
  - On ack the data and err are discarded → FETCH (new pc) if fetch_en=1, else IDLE.
- FAULT: imem_req=0, ir_valid=0; only reset exits.
- Redirect has the highest priority in every state except FAULT. It sets pc={redirect_pc[ADDR_W-1:2],2'b00} and clears ir_valid.
  - IDLE: stay IDLE.
  - FULL: squash the held instruction, even if ir_ready=1 in the same cycle; that cycle is not a transfer. → FETCH if fetch_en=1, else IDLE.
  - FETCH without ack: → DRAIN.
  - FETCH with ack in the same cycle: data and err are discarded → FETCH at the new pc.
  - DRAIN: pc updated again; stay DRAIN; the latest redirect wins.
- Dropping fetch_en during FETCH does not cancel the request; it completes normally into FULL.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; 0xFFFF_FFFC+4 = 0.

## Timing
- All outputs are registered (Moore); there are no combinational input-to-output paths.
- fetch_en high in IDLE at edge n → imem_req=1 after edge n.
- imem_ack sampled at edge k → ir_valid=1 after edge k (1-cycle latency).
- Handshake at edge m → next imem_req=1 after edge m. With zero-wait memory (ack the cycle after req), this gives one instruction per 3 cycles.
- Redirect at edge r takes effect after edge r. Earliest new request is after edge r, or after the drain ack edge if a request was outstanding.
- Reset asserted mid-request drops imem_req asynchronously. The memory must tolerate withdrawal on reset only.

## Structure
- Shared package kgp_pkg:
  - fetch_state_t enum (IDLE, FETCH, DRAIN, FULL, FAULT)
  - INSTR_W=32
  - PC_STEP=4
- Single module. No sub-module is needed; pc, the request address register and the IR latch are simple enough to stay inline.

## Test plan
- Basic fetch: RESET_PC=0, fetch_en=1, memory acks each req after 2 cycles with 0x4000_0005, ir_ready=1 → ir=0x4000_0005, ir_pc=0, npc=4. Second request at imem_addr=4 issued the cycle after the handshake.
- Back-pressure: hold ir_ready=0 for 5 cycles in FULL → ir_valid stays 1, ir unchanged, imem_req stays 0. Then ir_ready=1 → one handshake, next req at pc+4.
- Redirect during outstanding request: redirect, redirect_pc=0x103 while imem_addr=0x8 awaits ack → req held at 0x8 until ack. Data not presented (ir_valid stays 0). Next req at 0x100.
- Redirect in FULL with ir_ready=1 in the same cycle → no transfer counted, ir_valid=0, next req at redirect target.
- Bus error: ack with imem_err=1 → fault=1, imem_req=0, ir_valid=0, no further requests. Reset → all outputs return to reset values, pc=RESET_PC.
- Wrap-around: redirect_pc=0xFFFF_FFFC, fetch completes → npc=0, next req imem_addr=0.
